// File: rtl/sequence_checker_if.sv
// Stream and status bundle between the pattern generator and its sequence checker.
// master drives the byte stream, slave (the checker) returns lock/error status.
interface sequence_checker_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic [7:0]       in_data;
   logic             clear_count;
   logic             locked;
   logic [1:0]       state;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [7:0]       exp_data;

   modport master (
      output in_valid, in_data, clear_count,
      input  locked, state, err_pulse, err_count, exp_data
   );

   modport slave (
      input  in_valid, in_data, clear_count,
      output locked, state, err_pulse, err_count, exp_data
   );
endinterface

// File: rtl/sequence_checker.sv
// Locks onto the 8-byte generator pattern (keyed on AF), then counts mismatched
// bytes while locked and drops lock after MISS_LIMIT consecutive misses.
module sequence_checker #(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned MISS_LIMIT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input logic               clk,
   input logic               reset,
   sequence_checker_if.slave bus
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hAF;
   localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
   localparam logic [2:0] MISS_N    = 3'(MISS_LIMIT);

   state_t           st;
   logic [2:0]       idx;
   logic [3:0]       run;
   logic [2:0]       miss;
   logic             locked_q;
   logic             err_pulse_q;
   logic [CNT_W-1:0] err_count_q;

   logic [7:0]       exp_byte;
   logic             match;
   logic             is_sync;
   logic [3:0]       run_inc;
   logic [2:0]       miss_inc;

   always_comb begin
      exp_byte = 8'h00;
      case (idx)
         3'd0: exp_byte = 8'hAF;
         3'd1: exp_byte = 8'hBC;
         3'd2: exp_byte = 8'hE2;
         3'd3: exp_byte = 8'h78;
         3'd4: exp_byte = 8'hFF;
         3'd5: exp_byte = 8'hE2;
         3'd6: exp_byte = 8'h0B;
         3'd7: exp_byte = 8'h8D;
         default: exp_byte = 8'h00;
      endcase
   end

   always_comb begin
      match    = (bus.in_data == exp_byte);
      is_sync  = (bus.in_data == SYNC_BYTE);
      run_inc  = run + 4'd1;
      miss_inc = miss + 3'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= HUNT;
         idx         <= '0;
         run         <= '0;
         miss        <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_pulse_q <= 1'b0;
         if (bus.in_valid) begin
            case (st)
               HUNT: begin
                  if (is_sync) begin
                     st  <= VERIFY;
                     idx <= 3'd1;
                     run <= 4'd1;
                  end else begin
                     idx <= '0;
                  end
               end
               VERIFY: begin
                  if (match) begin
                     run <= run_inc;
                     idx <= idx + 3'd1;
                     if (run_inc == LOCK_N) begin
                        st       <= LOCKED;
                        locked_q <= 1'b1;
                        miss     <= '0;
                     end
                  end else if (is_sync) begin
                     idx <= 3'd1;
                     run <= 4'd1;
                  end else begin
                     st  <= HUNT;
                     idx <= '0;
                     run <= '0;
                  end
               end
               LOCKED: begin
                  idx <= idx + 3'd1;
                  if (match) begin
                     miss <= '0;
                  end else begin
                     err_pulse_q <= 1'b1;
                     if (err_count_q != '1)
                        err_count_q <= err_count_q + 1'b1;
                     // losing lock discards the offending byte rather than re-hunting on it
                     if (miss_inc == MISS_N) begin
                        st       <= HUNT;
                        locked_q <= 1'b0;
                        idx      <= '0;
                        run      <= '0;
                        miss     <= '0;
                     end else begin
                        miss <= miss_inc;
                     end
                  end
               end
               default: begin
                  st  <= HUNT;
                  idx <= '0;
                  run <= '0;
               end
            endcase
         end
         // clear wins over an increment on the same edge
         if (bus.clear_count)
            err_count_q <= '0;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.state     = st;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.exp_data  = exp_byte;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: acquisition, errors, loss of lock, clear,
// async reset, plus a narrow-counter instance for saturation.
module tb_sequence_checker;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [7:0] seq [8];

   sequence_checker_if #(.CNT_W(16)) bus ();
   sequence_checker_if #(.CNT_W(2))  bus2 ();

   sequence_checker #(
      .LOCK_COUNT (8),
      .MISS_LIMIT (3),
      .CNT_W      (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // second instance: fast lock, long miss tolerance, 2-bit counter
   sequence_checker #(
      .LOCK_COUNT (2),
      .MISS_LIMIT (7),
      .CNT_W      (2)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   assign bus2.in_valid    = bus.in_valid;
   assign bus2.in_data     = bus.in_data;
   assign bus2.clear_count = bus.clear_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic clr = 1'b0);
      bus.in_valid    = v;
      bus.in_data     = d;
      bus.clear_count = clr;
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.clear_count = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      seq[0] = 8'hAF; seq[1] = 8'hBC; seq[2] = 8'hE2; seq[3] = 8'h78;
      seq[4] = 8'hFF; seq[5] = 8'hE2; seq[6] = 8'h0B; seq[7] = 8'h8D;
      reset           = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_data     = 8'h00;
      bus.clear_count = 1'b0;

      @(posedge clk);
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_pulse", 32'(bus.err_pulse), 32'd0);
      chk("rst_count", 32'(bus.err_count), 32'd0);
      chk("rst_exp", 32'(bus.exp_data), 32'hAF);
      reset = 1'b0;

      // clean acquisition
      for (int i = 0; i < 8; i++) begin
         step(1'b1, seq[i]);
         chk("acq_state", 32'(bus.state), (i < 7) ? 32'd1 : 32'd2);
         chk("acq_locked", 32'(bus.locked), (i < 7) ? 32'd0 : 32'd1);
      end
      chk("acq_exp", 32'(bus.exp_data), 32'hAF);

      for (int i = 0; i < 16; i++) begin
         step(1'b1, seq[i % 8]);
         chk("clean_pulse", 32'(bus.err_pulse), 32'd0);
         chk("clean_state", 32'(bus.state), 32'd2);
      end
      chk("clean_count", 32'(bus.err_count), 32'd0);

      // single corrupt byte at idx 2
      step(1'b1, 8'hAF);
      step(1'b1, 8'hBC);
      step(1'b1, 8'hE3);
      chk("bad_pulse", 32'(bus.err_pulse), 32'd1);
      chk("bad_count", 32'(bus.err_count), 32'd1);
      chk("bad_locked", 32'(bus.locked), 32'd1);
      chk("bad_exp", 32'(bus.exp_data), 32'h78);
      step(1'b1, 8'h78);
      chk("noslip_pulse", 32'(bus.err_pulse), 32'd0);
      chk("noslip_count", 32'(bus.err_count), 32'd1);
      chk("noslip_exp", 32'(bus.exp_data), 32'hFF);
      step(1'b1, 8'hFF);
      step(1'b1, 8'hE2);
      step(1'b1, 8'h0B);
      step(1'b1, 8'h8D);
      chk("period_exp", 32'(bus.exp_data), 32'hAF);
      chk("period_locked", 32'(bus.locked), 32'd1);

      // clear with no valid byte; FSM untouched
      step(1'b0, 8'h00, 1'b1);
      chk("clr_count", 32'(bus.err_count), 32'd0);
      chk("clr_state", 32'(bus.state), 32'd2);

      // three consecutive misses drop lock
      step(1'b1, 8'h00);
      chk("miss1_count", 32'(bus.err_count), 32'd1);
      chk("miss1_locked", 32'(bus.locked), 32'd1);
      step(1'b1, 8'h00);
      chk("miss2_count", 32'(bus.err_count), 32'd2);
      chk("miss2_state", 32'(bus.state), 32'd2);
      step(1'b1, 8'h00);
      chk("miss3_count", 32'(bus.err_count), 32'd3);
      chk("miss3_pulse", 32'(bus.err_pulse), 32'd1);
      chk("miss3_locked", 32'(bus.locked), 32'd0);
      chk("miss3_state", 32'(bus.state), 32'd0);
      chk("miss3_exp", 32'(bus.exp_data), 32'hAF);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, seq[i]);
         if (i == 0) chk("relock_verify", 32'(bus.state), 32'd1);
      end
      chk("relock_locked", 32'(bus.locked), 32'd1);
      chk("relock_count", 32'(bus.err_count), 32'd3);

      // in_valid toggling while locked
      for (int i = 0; i < 8; i++) begin
         step(1'b1, seq[i]);
         step(1'b0, 8'h00);
         chk("tog_exp", 32'(bus.exp_data), 32'(seq[(i + 1) % 8]));
         chk("tog_pulse", 32'(bus.err_pulse), 32'd0);
      end
      chk("tog_count", 32'(bus.err_count), 32'd3);
      chk("tog_state", 32'(bus.state), 32'd2);

      // clear coincident with a mismatch
      step(1'b1, 8'h00, 1'b1);
      chk("clrmis_pulse", 32'(bus.err_pulse), 32'd1);
      chk("clrmis_count", 32'(bus.err_count), 32'd0);
      chk("clrmis_locked", 32'(bus.locked), 32'd1);
      for (int i = 1; i < 8; i++) step(1'b1, seq[i]);
      chk("clrmis_after_count", 32'(bus.err_count), 32'd0);
      chk("clrmis_after_exp", 32'(bus.exp_data), 32'hAF);

      // stream entered mid-sequence
      pulse_reset();
      for (int i = 2; i < 8; i++) begin
         step(1'b1, seq[i]);
         chk("mid_state", 32'(bus.state), 32'd0);
         chk("mid_exp", 32'(bus.exp_data), 32'hAF);
      end
      for (int i = 0; i < 8; i++) step(1'b1, seq[i]);
      chk("mid_locked", 32'(bus.locked), 32'd1);
      chk("mid_count", 32'(bus.err_count), 32'd0);

      // AF arriving at idx 3 restarts VERIFY
      pulse_reset();
      step(1'b1, 8'hAF);
      step(1'b1, 8'hBC);
      step(1'b1, 8'hE2);
      chk("vaf_pre_exp", 32'(bus.exp_data), 32'h78);
      step(1'b1, 8'hAF);
      chk("vaf_state", 32'(bus.state), 32'd1);
      chk("vaf_exp", 32'(bus.exp_data), 32'hBC);
      for (int i = 1; i < 7; i++) step(1'b1, seq[i]);
      chk("vaf_run7_state", 32'(bus.state), 32'd1);
      step(1'b1, 8'h8D);
      chk("vaf_lock_state", 32'(bus.state), 32'd2);
      chk("vaf_lock_locked", 32'(bus.locked), 32'd1);

      // other byte at idx 3 returns to HUNT
      pulse_reset();
      step(1'b1, 8'hAF);
      step(1'b1, 8'hBC);
      step(1'b1, 8'hE2);
      step(1'b1, 8'h55);
      chk("v55_state", 32'(bus.state), 32'd0);
      chk("v55_exp", 32'(bus.exp_data), 32'hAF);

      // async reset between edges while locked with an error pending
      pulse_reset();
      for (int i = 0; i < 8; i++) step(1'b1, seq[i]);
      step(1'b1, 8'h00);
      chk("pre_rst_pulse", 32'(bus.err_pulse), 32'd1);
      chk("pre_rst_count", 32'(bus.err_count), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("async_state", 32'(bus.state), 32'd0);
      chk("async_locked", 32'(bus.locked), 32'd0);
      chk("async_pulse", 32'(bus.err_pulse), 32'd0);
      chk("async_count", 32'(bus.err_count), 32'd0);
      chk("async_exp", 32'(bus.exp_data), 32'hAF);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // narrow counter saturates while err_pulse keeps firing
      step(1'b1, 8'hAF);
      chk("sat_verify", 32'(bus2.state), 32'd1);
      step(1'b1, 8'hBC);
      chk("sat_locked", 32'(bus2.locked), 32'd1);
      step(1'b1, 8'h00);
      chk("sat_c1", 32'(bus2.err_count), 32'd1);
      step(1'b1, 8'h00);
      chk("sat_c2", 32'(bus2.err_count), 32'd2);
      step(1'b1, 8'h00);
      chk("sat_c3", 32'(bus2.err_count), 32'd3);
      step(1'b1, 8'h00);
      chk("sat_hold", 32'(bus2.err_count), 32'd3);
      chk("sat_pulse", 32'(bus2.err_pulse), 32'd1);
      chk("sat_still_locked", 32'(bus2.locked), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Downstream consumer of the 8-byte pattern generator's output stream.
- Compares each valid byte against the fixed expected sequence and acquires lock on the stream.
- Tracks errors while locked and drops lock after repeated consecutive misses.
- Used as the self-check stage in the generator test path, with status exported to debug/LEDs.

Parameters:
LOCK_COUNT, 8, consecutive matching bytes (including the initial AF) needed to declare lock; legal 2..15
MISS_LIMIT, 3, consecutive mismatches while locked that force loss of lock; legal 1..7
CNT_W, 16, width of error counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_data for this cycle (connects to generator enable)
in_data  input  8  byte from generator
clear_count  input  1  synchronous clear of err_count
locked  output  1  stream locked to expected sequence
state  output  2  FSM state: 0 HUNT, 1 VERIFY, 2 LOCKED
err_pulse  output  1  one-cycle pulse per mismatched byte while LOCKED
err_count  output  CNT_W  saturating count of mismatches while LOCKED
exp_data  output  8  expected value for next valid byte (SEQ[idx])

Behaviour:
- SEQ (constant, index 0..7) = AF BC E2 78 FF E2 0B 8D.
- idx: 3-bit expected index; wraps 7->0.
- run: match-run counter, 4 bits.
- miss: consecutive-miss counter, 3 bits.
- Reset (async, immediate, also mid-operation): state=HUNT, idx=0, run=0, miss=0, locked=0, err_pulse=0, err_count=0, so exp_data=AF.
- All outputs are registered except exp_data, which decodes registered idx.
- Cycles with in_valid=0: no state change, err_pulse=0, clear_count still acts.
- HUNT, valid byte:
  - == AF: go to VERIFY, idx=1, run=1.
  - Otherwise: stay in HUNT, idx=0.
  - No errors are counted in HUNT.
- VERIFY, valid byte:
  - == SEQ[idx]: run+1, idx+1. If run+1 == LOCK_COUNT, go to LOCKED with locked=1 on the same edge and miss=0.
  - Mismatch, byte == AF: restart VERIFY with idx=1, run=1.
  - Mismatch, any other byte: go to HUNT, idx=0, run=0.
  - No err_pulse and no counting in VERIFY.
- LOCKED, valid byte: idx always advances (+1 mod 8), so single corrupt bytes do not slip alignment.
  - Match: miss=0, err_pulse=0.
  - Mismatch: err_pulse=1 for that cycle, err_count+1 (saturates at all-ones), miss+1.
  - If miss+1 == MISS_LIMIT: go to HUNT on the same edge; locked=0, idx=0, run=0, miss=0. The offending byte is counted but is not re-examined for AF.
- Latency: err_pulse, err_count, locked and state reflect a byte on the edge that samples it (visible the cycle after it is presented).
- clear_count=1: err_count=0 next edge. It takes priority over a simultaneous increment, and does not affect FSM or locked.
- Saturation: err_count holds at 2^CNT_W-1 and err_pulse still fires.
- Duplicate E2 in SEQ: acquisition keys only on AF (unique in SEQ), so there is no ambiguous lock.

Test Plan:
- Reset, then AF BC E2 78 FF E2 0B 8D with in_valid=1 each cycle -> state HUNT->VERIFY->LOCKED; locked=1 after the 8D edge; then 16 more correct bytes -> err_count=0, err_pulse never high.
- Locked, idx=2 byte sent as E3 instead of E2, rest correct -> err_pulse for exactly one cycle; err_count=1; locked stays 1; next byte 78 matches (no slip).
- Locked, three consecutive 00 bytes -> err_count=3; locked=0 and state=HUNT after the third; following AF BC ... 8D relocks after 8 bytes; err_count stays 3.
- From reset, stream entered mid-sequence: E2 78 FF E2 0B 8D AF BC E2 78 FF E2 0B 8D -> no VERIFY until AF; locked after the second 8D; err_count=0.
- VERIFY at idx=3 receives AF -> state stays VERIFY, exp_data=BC; a full clean period then locks. Same position receiving 55 -> state HUNT, exp_data=AF.
- Mixed corner cases:
  - Locked clean stream with in_valid toggling 1/0 -> no errors, idx advances only on valid.
  - clear_count asserted on the same edge as a mismatch -> err_count=0.
  - reset pulsed mid-LOCKED between clock edges -> all outputs zero (exp_data=AF) immediately, before next clk.
